sync_fifo_mc: RTL and testbench

Single-clock, multi-channel FIFO: NCH independent logical queues sharing one storage array, each with its own pointers, full/empty and programmable almost-full/almost-empty flags. It is the parametrised successor to the team's dual-clock FIFO and is used where several producer streams inside one clock domain are buffered toward a shared consumer. One write and one read per cycle are accepted, to the same or different channels.

---
 rtl/sync_fifo_mc_pkg.sv | 20 ++
 rtl/sync_fifo_mc_if.sv | 53 +++++
 rtl/sync_fifo_mc_ch_ctrl.sv | 90 +++++++++
 rtl/sync_fifo_mc.sv | 127 ++++++++++++
 tb/tb_sync_fifo_mc.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_mc_pkg.sv
// ---------------------------------------------------------------------------
// sync_fifo_mc_pkg
// Shared definitions for the multi-channel synchronous FIFO:
//   - chw_of(): width of a channel index for a given channel count (min 1)
//   - default pointer/count typedefs derived from the default per-channel
//     address size (ASIZE + 1 bits, the extra bit separates full from empty)
// Optional feature macro used by the files of this block: SYNC_FIFO_MC_ERR_EN
// ---------------------------------------------------------------------------
package sync_fifo_mc_pkg;

  localparam int DEF_ASIZE = 5;

  typedef logic [DEF_ASIZE:0] ptr_t;
  typedef logic [DEF_ASIZE:0] count_t;

  function automatic int chw_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo_mc_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_mc_if
// Bus bundle between producers/consumer (master) and the FIFO (slave).
//   winc/wch/wdata          write request, channel, data
//   wfull/walmostfull       per-channel write-side flags
//   rinc/rch                read request, channel
//   rdata/rvalid            registered read data and its valid
//   rempty/ralmostempty     per-channel read-side flags
//   err_clr/ovf/udf         sticky error flags (only with SYNC_FIFO_MC_ERR_EN)
// ---------------------------------------------------------------------------
interface sync_fifo_mc_if
  import sync_fifo_mc_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int NCH   = 4,
  parameter int CHW   = chw_of(NCH)
);
  logic             winc;
  logic [CHW-1:0]   wch;
  logic [DSIZE-1:0] wdata;
  logic [NCH-1:0]   wfull;
  logic [NCH-1:0]   walmostfull;
  logic             rinc;
  logic [CHW-1:0]   rch;
  logic [DSIZE-1:0] rdata;
  logic             rvalid;
  logic [NCH-1:0]   rempty;
  logic [NCH-1:0]   ralmostempty;
`ifdef SYNC_FIFO_MC_ERR_EN
  logic             err_clr;
  logic [NCH-1:0]   ovf;
  logic [NCH-1:0]   udf;
`endif

  modport master (
    output winc, wch, wdata, rinc, rch,
    input  wfull, walmostfull, rdata, rvalid, rempty, ralmostempty
`ifdef SYNC_FIFO_MC_ERR_EN
    , output err_clr
    , input  ovf, udf
`endif
  );

  modport slave (
    input  winc, wch, wdata, rinc, rch,
    output wfull, walmostfull, rdata, rvalid, rempty, ralmostempty
`ifdef SYNC_FIFO_MC_ERR_EN
    , input  err_clr
    , output ovf, udf
`endif
  );

endinterface

// File: rtl/sync_fifo_mc_ch_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ch_ctrl
// Pointer/flag bookkeeping for one logical channel of sync_fifo_mc.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_wr_acc, i_rd_acc  accepted write / read strobes for this channel
//   o_waddr, o_raddr    low ASIZE bits of wptr / rptr (slot within channel)
//   o_full, o_empty     count == DEPTH / count == 0
//   o_afull, o_aempty   free slots <= AF threshold / count <= AE threshold
//   i_err_clr, i_ovf_set, i_udf_set, o_ovf, o_udf
//                       sticky error bits (only with SYNC_FIFO_MC_ERR_EN)
// ---------------------------------------------------------------------------
module fifo_ch_ctrl #(
  parameter int ASIZE                  = 5,
  parameter int ALMOST_FULL_THRESHOLD  = 4,
  parameter int ALMOST_EMPTY_THRESHOLD = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_acc,
  input  logic             i_rd_acc,
  output logic [ASIZE-1:0] o_waddr,
  output logic [ASIZE-1:0] o_raddr,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_afull,
  output logic             o_aempty
`ifdef SYNC_FIFO_MC_ERR_EN
  ,
  input  logic             i_err_clr,
  input  logic             i_ovf_set,
  input  logic             i_udf_set,
  output logic             o_ovf,
  output logic             o_udf
`endif
);

  localparam logic [ASIZE:0] DEPTH_P = {1'b1, {ASIZE{1'b0}}};
  localparam logic [31:0]    AF_U    = ALMOST_FULL_THRESHOLD;
  localparam logic [31:0]    AE_U    = ALMOST_EMPTY_THRESHOLD;

  logic [ASIZE:0] r_wptr;
  logic [ASIZE:0] r_rptr;
  logic [ASIZE:0] w_count;
  logic [ASIZE:0] w_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (i_rd_acc) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Modular difference of the (ASIZE+1)-bit pointers gives 0..DEPTH.
  assign w_count  = r_wptr - r_rptr;
  assign w_free   = DEPTH_P - w_count;

  assign o_waddr  = r_wptr[ASIZE-1:0];
  assign o_raddr  = r_rptr[ASIZE-1:0];
  assign o_empty  = (w_count == '0);
  assign o_full   = (w_count == DEPTH_P);
  assign o_afull  = (32'(w_free) <= AF_U);
  assign o_aempty = (32'(w_count) <= AE_U);

`ifdef SYNC_FIFO_MC_ERR_EN
  logic r_ovf;
  logic r_udf;

  // Clear has priority over a set arriving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (i_err_clr) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (i_ovf_set) r_ovf <= 1'b1;
      if (i_udf_set) r_udf <= 1'b1;
    end
  end

  assign o_ovf = r_ovf;
  assign o_udf = r_udf;
`endif

endmodule

// File: rtl/sync_fifo_mc.sv
// ---------------------------------------------------------------------------
// sync_fifo_mc
// Single-clock FIFO with NCH independent logical queues sharing one storage
// array (entry address = {channel, slot}). One write and one read per cycle,
// to the same or different channels.
// Ports:
//   clk   single clock, rising edge
//   rst   asynchronous active-high reset
//   bus   sync_fifo_mc_if.slave: winc/wch/wdata, wfull/walmostfull,
//         rinc/rch, rdata/rvalid (registered), rempty/ralmostempty,
//         err_clr/ovf/udf when SYNC_FIFO_MC_ERR_EN is defined
// Optional feature macro: SYNC_FIFO_MC_ERR_EN (sticky overflow/underflow).
// ---------------------------------------------------------------------------
module sync_fifo_mc
  import sync_fifo_mc_pkg::*;
#(
  parameter int DSIZE                  = 8,
  parameter int ASIZE                  = 5,
  parameter int NCH                    = 4,
  parameter int ALMOST_FULL_THRESHOLD  = 4,
  parameter int ALMOST_EMPTY_THRESHOLD = 2
) (
  input  logic          clk,
  input  logic          rst,
  sync_fifo_mc_if.slave bus
);

  localparam int CHW = chw_of(NCH);
  localparam int AW  = CHW + ASIZE;

  logic [NCH-1:0]   w_wsel;
  logic [NCH-1:0]   w_rsel;
  logic [NCH-1:0]   w_wr_acc;
  logic [NCH-1:0]   w_rd_acc;
  logic [NCH-1:0]   w_full;
  logic [NCH-1:0]   w_empty;
  logic [NCH-1:0]   w_afull;
  logic [NCH-1:0]   w_aempty;
  logic [ASIZE-1:0] w_waddr_ch [NCH];
  logic [ASIZE-1:0] w_raddr_ch [NCH];
  logic [AW-1:0]    w_waddr;
  logic [AW-1:0]    w_raddr;
  logic             w_wr_any;
  logic             w_rd_any;

  logic [DSIZE-1:0] r_mem [2**AW];
  logic [DSIZE-1:0] r_rdata;
  logic             r_rvalid;

`ifdef SYNC_FIFO_MC_ERR_EN
  logic [NCH-1:0]   w_ovf;
  logic [NCH-1:0]   w_udf;
`endif

  // An index >= NCH matches no channel, so such requests fall away silently.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign w_wsel[c]   = bus.winc && (bus.wch == CHW'(c));
    assign w_rsel[c]   = bus.rinc && (bus.rch == CHW'(c));
    assign w_wr_acc[c] = w_wsel[c] && !w_full[c];
    assign w_rd_acc[c] = w_rsel[c] && !w_empty[c];

    fifo_ch_ctrl #(
      .ASIZE                  (ASIZE),
      .ALMOST_FULL_THRESHOLD  (ALMOST_FULL_THRESHOLD),
      .ALMOST_EMPTY_THRESHOLD (ALMOST_EMPTY_THRESHOLD)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .i_wr_acc (w_wr_acc[c]),
      .i_rd_acc (w_rd_acc[c]),
      .o_waddr  (w_waddr_ch[c]),
      .o_raddr  (w_raddr_ch[c]),
      .o_full   (w_full[c]),
      .o_empty  (w_empty[c]),
      .o_afull  (w_afull[c]),
      .o_aempty (w_aempty[c])
`ifdef SYNC_FIFO_MC_ERR_EN
      ,
      .i_err_clr (bus.err_clr),
      .i_ovf_set (w_wsel[c] && w_full[c]),
      .i_udf_set (w_rsel[c] && w_empty[c]),
      .o_ovf     (w_ovf[c]),
      .o_udf     (w_udf[c])
`endif
    );
  end

  always_comb begin
    w_waddr = '0;
    w_raddr = '0;
    for (int c = 0; c < NCH; c++) begin
      if (w_wsel[c]) w_waddr = {CHW'(c), w_waddr_ch[c]};
      if (w_rsel[c]) w_raddr = {CHW'(c), w_raddr_ch[c]};
    end
  end

  assign w_wr_any = |w_wr_acc;
  assign w_rd_any = |w_rd_acc;

  // A same-channel write and read never hit the same slot: the read needs
  // count > 0 and the write needs count < DEPTH, so the pointers differ.
  always_ff @(posedge clk) begin
    if (w_wr_any) r_mem[w_waddr] <= bus.wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_rd_any;
      if (w_rd_any) r_rdata <= r_mem[w_raddr];
    end
  end

  assign bus.wfull        = w_full;
  assign bus.walmostfull  = w_afull;
  assign bus.rempty       = w_empty;
  assign bus.ralmostempty = w_aempty;
  assign bus.rdata        = r_rdata;
  assign bus.rvalid       = r_rvalid;
`ifdef SYNC_FIFO_MC_ERR_EN
  assign bus.ovf          = w_ovf;
  assign bus.udf          = w_udf;
`endif

endmodule

// File: tb/tb_sync_fifo_mc.sv
module tb_sync_fifo_mc;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_tot;
  logic [7:0] sb [$];

  sync_fifo_mc_if #(.DSIZE(8), .NCH(4), .CHW(2)) bus ();

  sync_fifo_mc #(
    .DSIZE(8), .ASIZE(5), .NCH(4),
    .ALMOST_FULL_THRESHOLD(4), .ALMOST_EMPTY_THRESHOLD(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // One cycle of stimulus; returns 1 time unit after the active edge.
  task automatic op(input logic wi, input logic [1:0] wc, input logic [7:0] wd,
                    input logic ri, input logic [1:0] rc);
    bus.winc  = wi;
    bus.wch   = wc;
    bus.wdata = wd;
    bus.rinc  = ri;
    bus.rch   = rc;
    @(posedge clk);
    #1;
    bus.winc  = 1'b0;
    bus.rinc  = 1'b0;
  endtask

  // Monitor: every presented word must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.rvalid) begin
      if (sb.size() == 0) begin
        n_tot++;
        $display("FAIL rdata_unexpected: got 0x%0h with rvalid, expected no word", bus.rdata);
      end else begin
        chk("rdata", {24'b0, bus.rdata}, {24'b0, sb.pop_front()});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0;
    n_tot  = 0;
    rst    = 1'b1;
    bus.winc = 1'b0; bus.wch = '0; bus.wdata = '0;
    bus.rinc = 1'b0; bus.rch = '0;
`ifdef SYNC_FIFO_MC_ERR_EN
    bus.err_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_rempty",       {28'b0, bus.rempty},       32'hF);
    chk("rst_ralmostempty", {28'b0, bus.ralmostempty}, 32'hF);
    chk("rst_wfull",        {28'b0, bus.wfull},        32'h0);
    chk("rst_walmostfull",  {28'b0, bus.walmostfull},  32'h0);
    chk("rst_rvalid",       {31'b0, bus.rvalid},       32'h0);
    chk("rst_rdata",        {24'b0, bus.rdata},        32'h0);
`ifdef SYNC_FIFO_MC_ERR_EN
    chk("rst_ovf", {28'b0, bus.ovf}, 32'h0);
    chk("rst_udf", {28'b0, bus.udf}, 32'h0);
`endif

    // Fill ch2 with 0xA0..0xBF
    for (int i = 1; i <= 32; i++) begin
      op(1'b1, 2'd2, 8'(8'hA0 + i - 1), 1'b0, 2'd0);
      if (i == 1)  chk("fill_rempty_1", {28'b0, bus.rempty}, 32'hB);
      if (i == 2)  chk("fill_ae_2", {31'b0, bus.ralmostempty[2]}, 32'h1);
      if (i == 3)  chk("fill_ae_3", {31'b0, bus.ralmostempty[2]}, 32'h0);
      if (i == 27) chk("fill_af_27", {31'b0, bus.walmostfull[2]}, 32'h0);
      if (i == 28) chk("fill_af_28", {31'b0, bus.walmostfull[2]}, 32'h1);
      if (i == 31) chk("fill_full_31", {31'b0, bus.wfull[2]}, 32'h0);
      if (i == 32) chk("fill_full_32", {28'b0, bus.wfull}, 32'h4);
    end
    op(1'b1, 2'd2, 8'hC0, 1'b0, 2'd0);
    chk("ovf_write_full", {28'b0, bus.wfull}, 32'h4);
    chk("ovf_others_empty", {28'b0, bus.rempty}, 32'hB);
`ifdef SYNC_FIFO_MC_ERR_EN
    chk("ovf_flag", {28'b0, bus.ovf}, 32'h4);
`endif

    // Interleaved channels ch0/ch3
    op(1'b1, 2'd0, 8'h10, 1'b0, 2'd0);
    op(1'b1, 2'd3, 8'h30, 1'b0, 2'd0);
    op(1'b1, 2'd0, 8'h11, 1'b0, 2'd0);
    op(1'b1, 2'd3, 8'h31, 1'b0, 2'd0);
    chk("ilv_rempty", {28'b0, bus.rempty}, 32'h2);
    sb.push_back(8'h30); op(1'b0, 2'd0, 8'h00, 1'b1, 2'd3);
    chk("ilv_rvalid_0", {31'b0, bus.rvalid}, 32'h1);
    sb.push_back(8'h10); op(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
    chk("ilv_rvalid_1", {31'b0, bus.rvalid}, 32'h1);
    sb.push_back(8'h31); op(1'b0, 2'd0, 8'h00, 1'b1, 2'd3);
    chk("ilv_rvalid_2", {31'b0, bus.rvalid}, 32'h1);
    sb.push_back(8'h11); op(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
    chk("ilv_rvalid_3", {31'b0, bus.rvalid}, 32'h1);
    chk("ilv_rempty_after", {28'b0, bus.rempty}, 32'hB);

    // Empty ch1: same-cycle write+read, read must not bypass
    op(1'b1, 2'd1, 8'h55, 1'b1, 2'd1);
    chk("empty_rw_rvalid", {31'b0, bus.rvalid}, 32'h0);
    chk("empty_rw_rempty1", {31'b0, bus.rempty[1]}, 32'h0);
`ifdef SYNC_FIFO_MC_ERR_EN
    chk("empty_rw_udf", {28'b0, bus.udf}, 32'h2);
`endif
    sb.push_back(8'h55); op(1'b0, 2'd0, 8'h00, 1'b1, 2'd1);
    chk("ch1_read_rvalid", {31'b0, bus.rvalid}, 32'h1);
    chk("ch1_read_rempty1", {31'b0, bus.rempty[1]}, 32'h1);
`ifdef SYNC_FIFO_MC_ERR_EN
    // Clear beats a simultaneous underflow set
    bus.err_clr = 1'b1;
    op(1'b0, 2'd0, 8'h00, 1'b1, 2'd1);
    bus.err_clr = 1'b0;
    chk("errclr_ovf", {28'b0, bus.ovf}, 32'h0);
    chk("errclr_udf", {28'b0, bus.udf}, 32'h0);
`endif

    // Full ch2: steady write+read for 64 cycles across pointer wrap
    for (int k = 0; k < 64; k++) begin
      if (k < 32) sb.push_back(8'(8'hA0 + k));
      else        sb.push_back(8'(8'h40 + k - 31));
      op(1'b1, 2'd2, 8'(8'h40 + k), 1'b1, 2'd2);
      if (k == 0) chk("steady_first_wfull", {31'b0, bus.wfull[2]}, 32'h0);
`ifdef SYNC_FIFO_MC_ERR_EN
      if (k == 0) chk("steady_first_ovf", {28'b0, bus.ovf}, 32'h4);
`endif
    end
    chk("steady_end_wfull", {31'b0, bus.wfull[2]}, 32'h0);
    chk("steady_end_af", {31'b0, bus.walmostfull[2]}, 32'h1);
    for (int j = 0; j < 31; j++) begin
      sb.push_back(8'(8'h61 + j));
      op(1'b0, 2'd0, 8'h00, 1'b1, 2'd2);
    end
    chk("drain_rempty", {28'b0, bus.rempty}, 32'hF);

    // Reset mid-burst on ch0 with 10 words stored
    for (int i = 0; i < 10; i++) op(1'b1, 2'd0, 8'(8'h80 + i), 1'b0, 2'd0);
    chk("burst_rempty0", {31'b0, bus.rempty[0]}, 32'h0);
    bus.rinc = 1'b1;
    bus.rch  = 2'd0;
    @(posedge clk);
    #1;
    bus.rinc = 1'b0;
    chk("inflight_rvalid", {31'b0, bus.rvalid}, 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst_rvalid", {31'b0, bus.rvalid}, 32'h0);
    chk("midrst_rempty", {28'b0, bus.rempty}, 32'hF);
    chk("midrst_rdata",  {24'b0, bus.rdata}, 32'h0);
`ifdef SYNC_FIFO_MC_ERR_EN
    chk("midrst_ovf", {28'b0, bus.ovf}, 32'h0);
`endif
    #1;
    rst = 1'b0;
    op(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
    chk("postrst_read_rvalid", {31'b0, bus.rvalid}, 32'h0);
    chk("postrst_rempty0", {31'b0, bus.rempty[0]}, 32'h1);

    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
